// File: rtl/cond_flags_unit_if.sv
// EX-stage flag/condition bundle between the pipeline control (master) and
// the condition/flags unit (slave).
interface cond_flags_unit_if;
  logic       valid_ex;
  logic       stall;
  logic       flush;
  logic [3:0] cond;
  logic [1:0] flag_write;
  logic       q_write;
  logic       q_clear;
  logic [5:0] alu_flags;
  logic       it_start;
  logic [3:0] it_firstcond;
  logic [3:0] it_mask;
  logic       br_op;
  logic       cbz_op;
  logic       cbnz_op;
  logic       opnd_zero;
  logic       cond_ex;
  logic       branch_taken;
  logic [4:0] flags_q;
  logic       in_it;
  logic       it_err;

  modport master (
    output valid_ex, stall, flush, cond, flag_write, q_write, q_clear,
           alu_flags, it_start, it_firstcond, it_mask, br_op, cbz_op,
           cbnz_op, opnd_zero,
    input  cond_ex, branch_taken, flags_q, in_it, it_err
  );

  modport slave (
    input  valid_ex, stall, flush, cond, flag_write, q_write, q_clear,
           alu_flags, it_start, it_firstcond, it_mask, br_op, cbz_op,
           cbnz_op, opnd_zero,
    output cond_ex, branch_taken, flags_q, in_it, it_err
  );
endinterface

// File: rtl/cond_flags_unit.sv
// Architectural flags register, ARM condition evaluation, Thumb ITSTATE
// tracking and branch resolution for the EX stage.
module cond_flags_unit #(
  parameter int FLAGS_WIDTH = 6,
  parameter int COND_WIDTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cond_flags_unit_if.slave  io_ex
);

  logic                    r_q, r_n, r_z, r_c, r_v;
  logic [2*COND_WIDTH-1:0] r_itstate;
  logic                    r_it_err;

  logic                    w_in_it;
  logic [COND_WIDTH-1:0]   w_ec;
  logic                    w_pass;
  logic                    w_cond_ex;
  logic                    w_advance;
  logic                    w_flag_upd;
  logic                    w_it_reject;
  logic                    w_unused_rsvd;

  assign w_unused_rsvd = io_ex.alu_flags[FLAGS_WIDTH-1];

  // Inside an IT block the condition comes from ITSTATE, not the opcode.
  assign w_in_it = |r_itstate[3:0];
  assign w_ec    = w_in_it ? r_itstate[7:4] : io_ex.cond;

  always_comb begin
    w_pass = 1'b1;
    case (w_ec)
      4'd0:    w_pass = r_z;
      4'd1:    w_pass = ~r_z;
      4'd2:    w_pass = r_c;
      4'd3:    w_pass = ~r_c;
      4'd4:    w_pass = r_n;
      4'd5:    w_pass = ~r_n;
      4'd6:    w_pass = r_v;
      4'd7:    w_pass = ~r_v;
      4'd8:    w_pass = r_c & ~r_z;
      4'd9:    w_pass = ~r_c | r_z;
      4'd10:   w_pass = (r_n == r_v);
      4'd11:   w_pass = (r_n != r_v);
      4'd12:   w_pass = ~r_z & (r_n == r_v);
      4'd13:   w_pass = r_z | (r_n != r_v);
      default: w_pass = 1'b1;
    endcase
  end

  assign w_cond_ex   = io_ex.valid_ex & (io_ex.it_start | w_pass);
  assign w_advance   = io_ex.valid_ex & ~io_ex.stall & ~io_ex.flush;
  assign w_flag_upd  = w_advance & w_cond_ex & ~io_ex.it_start;
  assign w_it_reject = w_advance & io_ex.it_start &
                       (w_in_it | (io_ex.it_mask == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (w_flag_upd) begin
      if (io_ex.flag_write[1]) begin
        r_n <= io_ex.alu_flags[3];
        r_z <= io_ex.alu_flags[2];
      end
      if (io_ex.flag_write[0]) begin
        r_c <= io_ex.alu_flags[1];
        r_v <= io_ex.alu_flags[0];
      end
      // Saturation set beats an explicit clear issued by the same instruction.
      r_q <= (r_q & ~io_ex.q_clear) | (io_ex.q_write & io_ex.alu_flags[4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_itstate <= '0;
      r_it_err  <= 1'b0;
    end else begin
      r_it_err <= w_it_reject;
      if (io_ex.flush) begin
        r_itstate <= '0;
      end else if (w_advance) begin
        if (io_ex.it_start && !w_in_it) begin
          r_itstate <= {io_ex.it_firstcond, io_ex.it_mask};
        end else if (w_in_it) begin
          // A nested IT is rejected but still consumes its slot in the block.
          if (r_itstate[2:0] == 3'd0) begin
            r_itstate <= '0;
          end else begin
            r_itstate[4:0] <= {r_itstate[3:0], 1'b0};
          end
        end
      end
    end
  end

  assign io_ex.cond_ex      = w_cond_ex;
  assign io_ex.branch_taken = w_cond_ex &
                              (io_ex.br_op |
                               (io_ex.cbz_op & io_ex.opnd_zero) |
                               (io_ex.cbnz_op & ~io_ex.opnd_zero));
  assign io_ex.flags_q      = {r_q, r_n, r_z, r_c, r_v};
  assign io_ex.in_it        = w_in_it;
  assign io_ex.it_err       = r_it_err;

endmodule
